// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data paths; ports: clk, RST, if_* fetch side, dm_* data side, mem_* memory side, rdata, busy
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int MEM_LAT = 2
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_gnt,
  output logic          dm_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  localparam logic [3:0] FIRST = 4'(MEM_LAT - 1);
  state_t state, state_nx;
  logic [3:0] cnt;
  logic last_dm, own_dm, we_q, win, pick_dm, first;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  // data wins unless fetch also asks and data owned the port last
  always_comb begin
    win = if_req | dm_req;
    pick_dm = dm_req & (~if_req | ~last_dm);
    state_nx = IDLE;
    if (state == IDLE) state_nx = win ? ACCESS : IDLE;
    else if (state == ACCESS) state_nx = (cnt == 4'd0) ? RESP : ACCESS;
  end
  always_ff @(posedge clk) begin
    if (RST) begin
      state <= IDLE;
      cnt <= '0;
      last_dm <= 1'b0;
      own_dm <= 1'b0;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && win) begin
        own_dm <= pick_dm;
        last_dm <= pick_dm;
        we_q <= pick_dm & dm_we;
        addr_q <= pick_dm ? dm_addr : if_addr;
        wdata_q <= pick_dm ? dm_wdata : '0;
        cnt <= FIRST;
      end
      if (state == ACCESS) begin
        if (cnt != 4'd0) cnt <= cnt - 4'd1;
        if (cnt == 4'd0 && !we_q) rdata <= mem_rdata;
      end
    end
  end
  // cnt is loaded with FIRST on entry, so the first ACCESS cycle is cnt==FIRST
  assign mem_en    = state == ACCESS;
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = mem_en ? addr_q : '0;
  assign mem_wdata = mem_en ? wdata_q : '0;
  assign first     = mem_en & (cnt == FIRST);
  assign if_gnt    = first & ~own_dm;
  assign dm_gnt    = first & own_dm;
  assign if_rvalid = (state == RESP) & ~own_dm;
  assign dm_rvalid = (state == RESP) & own_dm;
  assign busy      = state != IDLE;
endmodule
